age_array_gen: RTL and testbench
================================

Name: age_array_gen

Overview:
Parametrised successor of the per-stream AGE array. Each of N_CH channels owns its own N_DIM-deep loop nest, so induction variables no longer come from a shared loop unit. Each channel emits a flat address, bank index and one-hot bank per element through an independent valid/ready output register. The block sits between the CSR configuration and the stream/bank crossbar, and adds backpressure, abort and completion signalling.

Parameters:
N_CH, 4, number of independent channels
N_DIM, 3, loop-nest depth per channel (dim 0 innermost)
NBIT_ADDR, 16, flat address width
NBIT_BOUND, 8, per-dimension bound width
NBIT_STRIDE, 16, per-dimension stride width
N_BANKS, 8, bank count (power of two, >=2); LOG_N_BANKS = $clog2(N_BANKS)
NBIT_LOG_BLOCK, 4, width of block-size exponent

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start pulse
abort_i  in  1  synchronous flush of all channels
cfg_ch_en_i  in  N_CH  channel enable
cfg_base_i  in  N_CH x NBIT_ADDR  base address
cfg_bound_i  in  N_CH x N_DIM x NBIT_BOUND  iteration count minus 1 per dim
cfg_stride_i  in  N_CH x N_DIM x NBIT_STRIDE  stride per dim
cfg_log_block_i  in  N_CH x NBIT_LOG_BLOCK  log2 of bank block size
cfg_start_bank_i  in  N_CH x LOG_N_BANKS  starting bank
cfg_lns_i  in  N_CH  1=load, 0=store
out_ready_i  in  N_CH  consumer ready
out_valid_o  out  N_CH  element valid
out_addr_o  out  N_CH x NBIT_ADDR  flat address
out_bank_idx_o  out  N_CH x LOG_N_BANKS  bank index
out_bank_o  out  N_CH x N_BANKS  one-hot of bank index
out_lns_o  out  N_CH  latched lns
out_last_o  out  N_CH  final element of the nest
busy_o  out  N_CH  channel in RUN
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_i=1 at an edge): all outputs 0, all channels IDLE, all IVs 0. Reset overrides start_i and abort_i, including mid-run.
- Per-channel FSM IDLE -> RUN -> IDLE.
- start_i is accepted only when no channel is busy and no output is valid; otherwise it is ignored.
- On an accepted start, each enabled channel latches all of its cfg_* values, clears its IVs and enters RUN. Disabled channels stay IDLE.
- Address: addr = (base + sum_d iv_d*stride_d) mod 2^NBIT_ADDR. Products and sum are truncated to NBIT_ADDR.
- Bank mapping:
  - bank_idx = (start_bank + (addr >> log_block)) mod N_BANKS
  - out_bank_o = 1 << bank_idx
- Output register:
  - Loads the current IV tuple when in RUN and (!out_valid_o || out_ready_i).
  - After a load, IVs advance odometer-style: dim 0 increments; on reaching its bound it wraps to 0 and carries into dim 1, and so on.
  - The element with every iv_d == bound_d sets out_last_o; the channel then leaves RUN (busy_o falls) at the same edge.
- Latency: start sampled at edge E0 -> first element loaded at edge E1 -> out_valid_o high after E1. With out_ready_i held 1, one element per cycle; total elements = prod(bound_d+1).
- Handshake: transfer occurs when valid && ready. While valid && !ready, all out_* fields hold stable. out_valid_o falls after the last transfer unless a new element loads at the same edge.
- done_o pulses for one cycle after the edge where the final last-element transfer across all started channels completes.
- Start with zero channels enabled: done_o pulses the cycle after start.
- abort_i: at the next edge all channels go IDLE, out_valid_o and out_last_o clear, busy_o clears, and no done_o pulse is produced. abort_i and start_i together: abort wins and start is dropped.
- Channels are fully independent. Backpressure on one channel does not stall the others.

Test Plan:
1. Channel 0 only, base 0x100, bounds {2,1}, strides {1,0x10}, ready=1 -> addresses 0x100, 0x101, 0x102, 0x110, 0x111, 0x112 on consecutive cycles; last on 0x112; done_o one cycle after that transfer; first valid 2 edges after start.
2. Same config, out_ready_i toggles 1,0,0,1 repeatedly -> no element dropped or duplicated; address held stable during ready=0; 6 transfers total.
3. N_BANKS=8, log_block=2, start_bank=3, base 0x0C, single element -> bank_idx 6, out_bank_o 0x40, out_lns_o equals cfg_lns_i.
4. base 0xFFFE, bound0=3, stride0=1 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap-around); bank indices follow the wrapped addresses.
5. Four channels with different bound products (6, 1, 12, disabled) and random ready -> each channel produces the correct count; done_o pulses only after the 12th transfer of channel 2; a start_i issued mid-run is ignored.
6. abort_i after 3 transfers -> valid/busy clear next cycle and no done_o. Then rst_i mid-run on a fresh run -> all outputs 0 the next cycle. A following start runs cleanly from iv=0.

Source files
------------

// File: rtl/age_array_gen.sv
// Multi-channel address generator: each channel walks its own N_DIM loop nest and
// emits flat address / bank through an independent valid-ready output register.
module age_array_gen #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned N_DIM          = 3,
    parameter int unsigned NBIT_ADDR      = 16,
    parameter int unsigned NBIT_BOUND     = 8,
    parameter int unsigned NBIT_STRIDE    = 16,
    parameter int unsigned N_BANKS        = 8,
    parameter int unsigned NBIT_LOG_BLOCK = 4,
    parameter int unsigned LOG_N_BANKS    = $clog2(N_BANKS)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                abort_i,
    input  logic [N_CH-1:0]                     cfg_ch_en_i,
    input  logic [N_CH*NBIT_ADDR-1:0]           cfg_base_i,
    input  logic [N_CH*N_DIM*NBIT_BOUND-1:0]    cfg_bound_i,
    input  logic [N_CH*N_DIM*NBIT_STRIDE-1:0]   cfg_stride_i,
    input  logic [N_CH*NBIT_LOG_BLOCK-1:0]      cfg_log_block_i,
    input  logic [N_CH*LOG_N_BANKS-1:0]         cfg_start_bank_i,
    input  logic [N_CH-1:0]                     cfg_lns_i,
    input  logic [N_CH-1:0]                     out_ready_i,
    output logic [N_CH-1:0]                     out_valid_o,
    output logic [N_CH*NBIT_ADDR-1:0]           out_addr_o,
    output logic [N_CH*LOG_N_BANKS-1:0]         out_bank_idx_o,
    output logic [N_CH*N_BANKS-1:0]             out_bank_o,
    output logic [N_CH-1:0]                     out_lns_o,
    output logic [N_CH-1:0]                     out_last_o,
    output logic [N_CH-1:0]                     busy_o,
    output logic                                done_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic            start_acc;
    logic [N_CH-1:0] xfer_last;
    logic [N_CH-1:0] pending_q, pending_d;
    logic            done_q, done_d;

    assign start_acc = start_i && !abort_i && !(|busy_o) && !(|out_valid_o);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t                   state_q, state_d;
        logic [NBIT_BOUND-1:0]    iv_q     [N_DIM];
        logic [NBIT_BOUND-1:0]    iv_next  [N_DIM];
        logic [NBIT_BOUND-1:0]    bound_q  [N_DIM];
        logic [NBIT_STRIDE-1:0]   stride_q [N_DIM];
        logic [NBIT_ADDR-1:0]     base_q;
        logic [NBIT_LOG_BLOCK-1:0] log_block_q;
        logic [LOG_N_BANKS-1:0]   start_bank_q;
        logic                     cfg_lns_q;
        logic                     valid_q, last_q, lns_q;
        logic [NBIT_ADDR-1:0]     addr_q, addr_calc, shifted;
        logic [LOG_N_BANKS-1:0]   bank_idx_q, bank_calc;
        logic [N_BANKS-1:0]       bank_q;
        logic                     at_end, carry, busy, load;

        always_comb begin
            addr_calc = base_q;
            for (int unsigned d = 0; d < N_DIM; d++)
                addr_calc = addr_calc + NBIT_ADDR'(iv_q[d]) * NBIT_ADDR'(stride_q[d]);
            shifted   = addr_calc >> log_block_q;
            bank_calc = start_bank_q + shifted[LOG_N_BANKS-1:0];
        end

        // Odometer advance: dim 0 counts, wrapping dims propagate a carry upward.
        always_comb begin
            at_end = 1'b1;
            carry  = 1'b1;
            for (int unsigned d = 0; d < N_DIM; d++) begin
                iv_next[d] = iv_q[d];
                if (iv_q[d] != bound_q[d]) at_end = 1'b0;
                if (carry) begin
                    if (iv_q[d] == bound_q[d]) begin
                        iv_next[d] = '0;
                    end else begin
                        iv_next[d] = iv_q[d] + NBIT_BOUND'(1);
                        carry      = 1'b0;
                    end
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) state_q <= S_IDLE;
            else       state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            if (abort_i) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:  if (start_acc && cfg_ch_en_i[g]) state_d = S_RUN;
                    S_RUN:   if (load && at_end)              state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end

        always_comb begin
            busy = (state_q == S_RUN);
            load = busy && (!valid_q || out_ready_i[g]);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q <= 1'b0; last_q <= 1'b0; lns_q <= 1'b0;
                addr_q <= '0; bank_idx_q <= '0; bank_q <= '0;
                base_q <= '0; log_block_q <= '0; start_bank_q <= '0; cfg_lns_q <= 1'b0;
                for (int unsigned d = 0; d < N_DIM; d++) begin
                    iv_q[d] <= '0; bound_q[d] <= '0; stride_q[d] <= '0;
                end
            end else if (abort_i) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (start_acc && cfg_ch_en_i[g]) begin
                base_q       <= cfg_base_i[g*NBIT_ADDR +: NBIT_ADDR];
                log_block_q  <= cfg_log_block_i[g*NBIT_LOG_BLOCK +: NBIT_LOG_BLOCK];
                start_bank_q <= cfg_start_bank_i[g*LOG_N_BANKS +: LOG_N_BANKS];
                cfg_lns_q    <= cfg_lns_i[g];
                for (int unsigned d = 0; d < N_DIM; d++) begin
                    iv_q[d]     <= '0;
                    bound_q[d]  <= cfg_bound_i[(g*N_DIM+d)*NBIT_BOUND +: NBIT_BOUND];
                    stride_q[d] <= cfg_stride_i[(g*N_DIM+d)*NBIT_STRIDE +: NBIT_STRIDE];
                end
            end else if (load) begin
                valid_q    <= 1'b1;
                last_q     <= at_end;
                lns_q      <= cfg_lns_q;
                addr_q     <= addr_calc;
                bank_idx_q <= bank_calc;
                bank_q     <= N_BANKS'(1) << bank_calc;
                for (int unsigned d = 0; d < N_DIM; d++) iv_q[d] <= iv_next[d];
            end else if (valid_q && out_ready_i[g]) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end

        assign out_valid_o[g]                                  = valid_q;
        assign out_last_o[g]                                   = last_q;
        assign out_lns_o[g]                                    = lns_q;
        assign busy_o[g]                                       = busy;
        assign out_addr_o[g*NBIT_ADDR +: NBIT_ADDR]            = addr_q;
        assign out_bank_idx_o[g*LOG_N_BANKS +: LOG_N_BANKS]    = bank_idx_q;
        assign out_bank_o[g*N_BANKS +: N_BANKS]                = bank_q;
        assign xfer_last[g]                                    = valid_q && last_q && out_ready_i[g];
    end

    // done fires when the last outstanding started channel hands off its final element.
    always_comb begin
        pending_d = pending_q & ~xfer_last;
        done_d    = (|pending_q) && (pending_d == '0);
        if (abort_i) begin
            pending_d = '0;
            done_d    = 1'b0;
        end else if (start_acc) begin
            pending_d = cfg_ch_en_i;
            done_d    = (cfg_ch_en_i == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: tb/tb_age_array_gen.sv
// Directed self-checking bench for age_array_gen with hand-computed address/bank sequences.
module tb_age_array_gen;

    localparam int N_CH = 4, N_DIM = 3, NA = 16, NB = 8, NS = 16, NBK = 8, NLB = 4, LNB = 3;

    logic                    clk = 1'b0;
    logic                    rst, start, abort;
    logic [N_CH-1:0]         ch_en, lns, ready;
    logic [N_CH*NA-1:0]      base;
    logic [N_CH*N_DIM*NB-1:0] bound;
    logic [N_CH*N_DIM*NS-1:0] stride;
    logic [N_CH*NLB-1:0]     log_block;
    logic [N_CH*LNB-1:0]     start_bank;
    logic [N_CH-1:0]         valid, last, lns_o, busy;
    logic [N_CH*NA-1:0]      addr;
    logic [N_CH*LNB-1:0]     bank_idx;
    logic [N_CH*NBK-1:0]     bank;
    logic                    done;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_addr [16];
    logic [2:0]  exp_bank [16];

    age_array_gen #(.N_CH(N_CH), .N_DIM(N_DIM), .NBIT_ADDR(NA), .NBIT_BOUND(NB),
                    .NBIT_STRIDE(NS), .N_BANKS(NBK), .NBIT_LOG_BLOCK(NLB)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .cfg_ch_en_i(ch_en), .cfg_base_i(base), .cfg_bound_i(bound), .cfg_stride_i(stride),
        .cfg_log_block_i(log_block), .cfg_start_bank_i(start_bank), .cfg_lns_i(lns),
        .out_ready_i(ready), .out_valid_o(valid), .out_addr_o(addr), .out_bank_idx_o(bank_idx),
        .out_bank_o(bank), .out_lns_o(lns_o), .out_last_o(last), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_ch(input int c, input logic en, input logic [15:0] b,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                          input logic [3:0] lb, input logic [2:0] sb, input logic l);
        ch_en[c] = en;
        base[c*NA +: NA] = b;
        bound[(c*N_DIM+0)*NB +: NB] = b0;
        bound[(c*N_DIM+1)*NB +: NB] = b1;
        bound[(c*N_DIM+2)*NB +: NB] = b2;
        stride[(c*N_DIM+0)*NS +: NS] = s0;
        stride[(c*N_DIM+1)*NS +: NS] = s1;
        stride[(c*N_DIM+2)*NS +: NS] = s2;
        log_block[c*NLB +: NLB] = lb;
        start_bank[c*LNB +: LNB] = sb;
        lns[c] = l;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Channel 0 only, ready held high: walks exp_addr/exp_bank[0..n-1].
    task automatic expect_stream(input int n);
        ready = '1;
        chk("first_busy", 32'(busy[0]), 32'd1);
        chk("first_notvalid", 32'(valid[0]), 32'd0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("valid_%0d", i), 32'(valid[0]), 32'd1);
            chk($sformatf("addr_%0d", i), 32'(addr[15:0]), 32'(exp_addr[i]));
            chk($sformatf("bidx_%0d", i), 32'(bank_idx[2:0]), 32'(exp_bank[i]));
            chk($sformatf("bank_%0d", i), 32'(bank[7:0]), 32'd1 << exp_bank[i]);
            chk($sformatf("last_%0d", i), 32'(last[0]), 32'(i == n - 1));
            chk($sformatf("busy_%0d", i), 32'(busy[0]), 32'(i != n - 1));
            chk($sformatf("nodone_%0d", i), 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("end_valid", 32'(valid[0]), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int k, cyc, held;
        logic [15:0] held_addr;
        int cnt [N_CH];
        int done_seen;
        logic done_exp;
        logic [N_CH-1:0] xf;

        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = '0;
        ch_en = '0; lns = '0; base = '0; bound = '0; stride = '0; log_block = '0; start_bank = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", addr[31:0], 32'd0);

        // 1: 2x3 nest at 0x100
        set_ch(0, 1'b1, 16'h0100, 8'd2, 8'd1, 8'd0, 16'h1, 16'h10, 16'h0, 4'd0, 3'd0, 1'b0);
        exp_addr[0] = 16'h100; exp_addr[1] = 16'h101; exp_addr[2] = 16'h102;
        exp_addr[3] = 16'h110; exp_addr[4] = 16'h111; exp_addr[5] = 16'h112;
        exp_bank[0] = 3'd0; exp_bank[1] = 3'd1; exp_bank[2] = 3'd2;
        exp_bank[3] = 3'd0; exp_bank[4] = 3'd1; exp_bank[5] = 3'd2;
        ready = '1;
        pulse_start();
        expect_stream(6);

        // 2: ready pattern 1,0,0,1
        ready = '0;
        pulse_start();
        k = 0; held = 0; held_addr = '0; cyc = 0;
        while (k < 6 && cyc < 60) begin
            ready[0] = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (valid[0]) begin
                if (held != 0) chk("bp_hold", 32'(addr[15:0]), 32'(held_addr));
                if (ready[0]) begin
                    chk($sformatf("bp_addr_%0d", k), 32'(addr[15:0]), 32'(exp_addr[k]));
                    chk($sformatf("bp_last_%0d", k), 32'(last[0]), 32'(k == 5));
                    k++; held = 0;
                end else begin
                    held = 1; held_addr = addr[15:0];
                end
            end
            cyc++;
            if (k < 6) @(negedge clk);
        end
        chk("bp_count", 32'(k), 32'd6);
        @(negedge clk);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_valid_clear", 32'(valid[0]), 32'd0);
        @(negedge clk);

        // 3: bank mapping, single element
        set_ch(0, 1'b1, 16'h000C, 8'd0, 8'd0, 8'd0, 16'h1, 16'h0, 16'h0, 4'd2, 3'd3, 1'b1);
        exp_addr[0] = 16'h000C; exp_bank[0] = 3'd6;
        pulse_start();
        ready = '1;
        @(negedge clk);
        chk("bm_bank", 32'(bank[7:0]), 32'h40);
        chk("bm_lns", 32'(lns_o[0]), 32'd1);
        chk("bm_idx", 32'(bank_idx[2:0]), 32'd6);
        chk("bm_last", 32'(last[0]), 32'd1);
        @(negedge clk);
        chk("bm_done", 32'(done), 32'd1);
        @(negedge clk);

        // 4: address wrap-around
        set_ch(0, 1'b1, 16'hFFFE, 8'd3, 8'd0, 8'd0, 16'h1, 16'h0, 16'h0, 4'd0, 3'd0, 1'b0);
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
        exp_bank[0] = 3'd6; exp_bank[1] = 3'd7; exp_bank[2] = 3'd0; exp_bank[3] = 3'd1;
        pulse_start();
        expect_stream(4);

        // 5: three independent channels, random ready, ignored mid-run start
        set_ch(0, 1'b1, 16'h0100, 8'd2, 8'd1, 8'd0, 16'h1, 16'h10, 16'h0, 4'd0, 3'd0, 1'b0);
        set_ch(1, 1'b1, 16'h0200, 8'd0, 8'd0, 8'd0, 16'h1, 16'h0, 16'h0, 4'd0, 3'd0, 1'b1);
        set_ch(2, 1'b1, 16'h0300, 8'd3, 8'd2, 8'd0, 16'h1, 16'h8, 16'h0, 4'd1, 3'd2, 1'b0);
        set_ch(3, 1'b0, 16'h0400, 8'd5, 8'd5, 8'd5, 16'h1, 16'h0, 16'h0, 4'd0, 3'd0, 1'b0);
        ready = '0;
        pulse_start();
        for (int c = 0; c < N_CH; c++) cnt[c] = 0;
        done_exp = 1'b0; done_seen = 0;
        for (int t = 0; t < 200; t++) begin
            ready = 4'($urandom_range(0, 15));
            start = (t == 4);
            chk("mc_done", 32'(done), 32'(done_exp));
            if (done) done_seen++;
            chk("mc_ch3_idle", 32'({valid[3], busy[3]}), 32'd0);
            if (valid[1]) chk("mc_ch1_addr", 32'(addr[31:16]), 32'h200);
            xf = valid & ready;
            for (int c = 0; c < N_CH; c++) if (xf[c]) cnt[c]++;
            done_exp = (xf != '0) && cnt[0] == 6 && cnt[1] == 1 && cnt[2] == 12;
            @(negedge clk);
        end
        start = 1'b0;
        chk("mc_cnt0", 32'(cnt[0]), 32'd6);
        chk("mc_cnt1", 32'(cnt[1]), 32'd1);
        chk("mc_cnt2", 32'(cnt[2]), 32'd12);
        chk("mc_cnt3", 32'(cnt[3]), 32'd0);
        chk("mc_done_once", 32'(done_seen), 32'd1);

        // 6a: abort after 3 transfers
        ch_en = 4'b0001;
        exp_addr[0] = 16'h100; exp_addr[1] = 16'h101; exp_addr[2] = 16'h102;
        exp_addr[3] = 16'h110; exp_addr[4] = 16'h111; exp_addr[5] = 16'h112;
        exp_bank[0] = 3'd0; exp_bank[1] = 3'd1; exp_bank[2] = 3'd2;
        exp_bank[3] = 3'd0; exp_bank[4] = 3'd1; exp_bank[5] = 3'd2;
        ready = '1;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("ab_pre_addr", 32'(addr[15:0]), 32'h110);
        abort = 1'b1; ready = '0; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("ab_valid", 32'(valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_last", 32'(last), 32'd0);
        for (int t = 0; t < 4; t++) begin
            chk("ab_nodone", 32'(done), 32'd0);
            chk("ab_stay_idle", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // 6b: reset mid-run, then a clean run
        pulse_start();
        @(negedge clk);
        chk("rr_running", 32'(valid[0]), 32'd1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rr_valid", 32'(valid), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_addr", addr[31:0], 32'd0);
        chk("rr_bank", bank[31:0], 32'd0);
        chk("rr_done", 32'(done), 32'd0);
        ready = '1;
        pulse_start();
        expect_stream(6);

        // zero enabled channels: done the cycle after start
        ch_en = '0;
        pulse_start();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("zero_done_clear", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
